// File: rtl/mem_port_arbiter.sv
// Shared memory port arbiter between IF fetches and MEM loads/stores.
// MEM wins arbitration unless IF has waited through STARVE_MAX MEM grants.
module mem_port_arbiter #(
  parameter int ADDR_L     = 32,
  parameter int DATA_L     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_L-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_L-1:0] if_rdata,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_len,
  input  logic [ADDR_L-1:0] mem_addr,
  input  logic [DATA_L-1:0] mem_wdata,
  output logic              mem_done,
  output logic [DATA_L-1:0] mem_rdata,
  output logic [ADDR_L-1:0] m_addr,
  output logic              m_re,
  output logic              m_we,
  output logic [1:0]        m_len,
  output logic [DATA_L-1:0] m_wdata,
  input  logic [DATA_L-1:0] m_rdata,
  output logic              busy
);

  localparam int LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int AW = $clog2(STARVE_MAX + 1);
  localparam logic [LW-1:0] LAT_INIT = LW'(MEM_LAT - 1);
  localparam logic [AW-1:0] AGE_MAX  = AW'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_e;

  state_e            state_q, state_d;
  logic              own_if_q, own_if_d;
  logic [AW-1:0]     age_q, age_d;
  logic [LW-1:0]     lat_q, lat_d;
  logic [ADDR_L-1:0] m_addr_q, m_addr_d;
  logic              m_re_q, m_re_d;
  logic              m_we_q, m_we_d;
  logic [1:0]        m_len_q, m_len_d;
  logic [DATA_L-1:0] m_wdata_q, m_wdata_d;
  logic              if_done_q, if_done_d;
  logic              mem_done_q, mem_done_d;
  logic [DATA_L-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_L-1:0] mem_rdata_q, mem_rdata_d;
  logic              busy_q, busy_d;
  logic              starved;

  assign starved = if_req && (age_q == AGE_MAX);

  always_comb begin
    state_d     = state_q;
    own_if_d    = own_if_q;
    age_d       = age_q;
    lat_d       = lat_q;
    m_addr_d    = m_addr_q;
    m_re_d      = m_re_q;
    m_we_d      = m_we_q;
    m_len_d     = m_len_q;
    m_wdata_d   = m_wdata_q;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    busy_d      = busy_q;
    case (state_q)
      IDLE: begin
        age_d = '0;
        if (mem_req && !starved) begin
          state_d   = ACCESS;
          own_if_d  = 1'b0;
          lat_d     = LAT_INIT;
          busy_d    = 1'b1;
          m_addr_d  = mem_addr;
          m_wdata_d = mem_wdata;
          m_we_d    = mem_we;
          m_re_d    = !mem_we;
          // length 2 is not a legal size; it is issued as a word
          m_len_d   = (mem_len == 2'd2) ? 2'd3 : mem_len;
          if (if_req) begin
            age_d = (age_q == AGE_MAX) ? age_q : age_q + AW'(1);
          end
        end else if (if_req) begin
          state_d   = ACCESS;
          own_if_d  = 1'b1;
          lat_d     = LAT_INIT;
          busy_d    = 1'b1;
          m_addr_d  = if_addr;
          m_wdata_d = '0;
          m_we_d    = 1'b0;
          m_re_d    = 1'b1;
          m_len_d   = 2'd3;
        end
      end
      ACCESS: begin
        if (lat_q == '0) begin
          state_d    = DONE;
          m_re_d     = 1'b0;
          m_we_d     = 1'b0;
          if_done_d  = own_if_q;
          mem_done_d = !own_if_q;
          if (own_if_q) begin
            if_rdata_d = m_rdata;
          end else if (m_re_q) begin
            mem_rdata_d = m_rdata;
          end
        end else begin
          lat_d = lat_q - LW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        m_re_d  = 1'b0;
        m_we_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      own_if_q    <= 1'b0;
      age_q       <= '0;
      lat_q       <= '0;
      m_addr_q    <= '0;
      m_re_q      <= 1'b0;
      m_we_q      <= 1'b0;
      m_len_q     <= '0;
      m_wdata_q   <= '0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      own_if_q    <= own_if_d;
      age_q       <= age_d;
      lat_q       <= lat_d;
      m_addr_q    <= m_addr_d;
      m_re_q      <= m_re_d;
      m_we_q      <= m_we_d;
      m_len_q     <= m_len_d;
      m_wdata_q   <= m_wdata_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      busy_q      <= busy_d;
    end
  end

  assign m_addr    = m_addr_q;
  assign m_re      = m_re_q;
  assign m_we      = m_we_q;
  assign m_len     = m_len_q;
  assign m_wdata   = m_wdata_q;
  assign if_done   = if_done_q;
  assign mem_done  = mem_done_q;
  assign if_rdata  = if_rdata_q;
  assign mem_rdata = mem_rdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios plus a randomized
// run against a timeline-based reference model of the arbitration rules.
module tb_mem_port_arbiter;
  localparam int AL  = 32;
  localparam int DL  = 32;
  localparam int LAT = 2;
  localparam int SM  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [AL-1:0] if_addr;
  logic          if_done;
  logic [DL-1:0] if_rdata;
  logic          mem_req;
  logic          mem_we;
  logic [1:0]    mem_len;
  logic [AL-1:0] mem_addr;
  logic [DL-1:0] mem_wdata;
  logic          mem_done;
  logic [DL-1:0] mem_rdata;
  logic [AL-1:0] m_addr;
  logic          m_re;
  logic          m_we;
  logic [1:0]    m_len;
  logic [DL-1:0] m_wdata;
  logic [DL-1:0] m_rdata;
  logic          busy;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(
    .ADDR_L(AL), .DATA_L(DL), .MEM_LAT(LAT), .STARVE_MAX(SM)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr),
    .if_done(if_done), .if_rdata(if_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_len(mem_len),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_done(mem_done), .mem_rdata(mem_rdata),
    .m_addr(m_addr), .m_re(m_re), .m_we(m_we), .m_len(m_len),
    .m_wdata(m_wdata), .m_rdata(m_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    if_req    = 1'b0;
    if_addr   = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_len   = 2'd0;
    mem_addr  = '0;
    mem_wdata = '0;
    m_rdata   = '0;
  endtask

  task automatic test_reset();
    idle_in();
    rst = 1'b1;
    #1 rst = 1'b0;
    #2;
    checks++;
    if ({m_re, m_we, busy, if_done, mem_done} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctl got %b exp 00000",
               {m_re, m_we, busy, if_done, mem_done});
    end
    checks++;
    if ({m_addr, m_len, m_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_port got %h/%h/%h exp 0", m_addr, m_len, m_wdata);
    end
    checks++;
    if ({if_rdata, mem_rdata} !== '0) begin
      errors++;
      $display("FAIL reset_rdata got %h/%h exp 0", if_rdata, mem_rdata);
    end
    @(negedge clk);
    rst = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_if_alone();
    if_req  = 1'b1;
    if_addr = 32'h0001_0054;
    m_rdata = 32'hDEAD_BEEF;
    tick();
    if_req = 1'b0;
    for (int k = 1; k <= LAT; k++) begin
      checks++;
      if ({m_re, m_we, busy, if_done} !== 4'b1010) begin
        errors++;
        $display("FAIL if_ctl N+%0d got %b exp 1010", k,
                 {m_re, m_we, busy, if_done});
      end
      checks++;
      if (m_addr !== 32'h0001_0054 || m_len !== 2'd3) begin
        errors++;
        $display("FAIL if_port N+%0d got %h/%0d exp 00010054/3", k,
                 m_addr, m_len);
      end
      tick();
    end
    checks++;
    if ({if_done, mem_done, m_re, busy} !== 4'b1001) begin
      errors++;
      $display("FAIL if_done N+3 got %b exp 1001",
               {if_done, mem_done, m_re, busy});
    end
    checks++;
    if (if_rdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL if_rdata got %h exp deadbeef", if_rdata);
    end
    tick();
    checks++;
    if ({if_done, busy} !== 2'b00) begin
      errors++;
      $display("FAIL if_end N+4 got %b exp 00", {if_done, busy});
    end
  endtask

  task automatic test_store();
    int we_n = 0;
    int re_n = 0;
    int dn_n = 0;
    mem_req  = 1'b1;
    mem_we   = 1'b0;
    mem_len  = 2'd3;
    mem_addr = 32'h3000;
    m_rdata  = 32'h1122_3344;
    tick();
    mem_req = 1'b0;
    tick();
    tick();
    checks++;
    if ({mem_done, if_done} !== 2'b10 || mem_rdata !== 32'h1122_3344) begin
      errors++;
      $display("FAIL load_done got %b/%h exp 10/11223344",
               {mem_done, if_done}, mem_rdata);
    end
    tick();
    mem_req   = 1'b1;
    mem_we    = 1'b1;
    mem_len   = 2'd0;
    mem_addr  = 32'h2000;
    mem_wdata = 32'hAB;
    m_rdata   = 32'hFFFF_FFFF;
    tick();
    mem_req = 1'b0;
    mem_we  = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (m_we) begin
        we_n++;
        checks++;
        if (m_wdata !== 32'hAB || m_addr !== 32'h2000 || m_len !== 2'd0) begin
          errors++;
          $display("FAIL store_port got %h/%h/%0d exp 000000ab/00002000/0",
                   m_wdata, m_addr, m_len);
        end
      end
      if (m_re) re_n++;
      if (mem_done) dn_n++;
      tick();
    end
    checks++;
    if (we_n != LAT || re_n != 0 || dn_n != 1) begin
      errors++;
      $display("FAIL store_counts got we=%0d re=%0d done=%0d exp %0d/0/1",
               we_n, re_n, dn_n, LAT);
    end
    checks++;
    if (mem_rdata !== 32'h1122_3344) begin
      errors++;
      $display("FAIL store_rdata got %h exp 11223344", mem_rdata);
    end
  endtask

  task automatic test_simul();
    if_req   = 1'b1;
    mem_req  = 1'b1;
    mem_we   = 1'b0;
    mem_len  = 2'd3;
    mem_addr = 32'h4000;
    if_addr  = 32'h0001_0080;
    tick();
    mem_req = 1'b0;
    tick();
    tick();
    checks++;
    if ({mem_done, if_done} !== 2'b10) begin
      errors++;
      $display("FAIL simul_mem_done N+3 got %b exp 10", {mem_done, if_done});
    end
    tick();
    tick();
    if_req = 1'b0;
    checks++;
    if (m_re !== 1'b1 || m_addr !== 32'h0001_0080) begin
      errors++;
      $display("FAIL simul_if_grant N+5 got %b/%h exp 1/00010080",
               m_re, m_addr);
    end
    tick();
    tick();
    checks++;
    if ({if_done, mem_done} !== 2'b10) begin
      errors++;
      $display("FAIL simul_if_done N+7 got %b exp 10", {if_done, mem_done});
    end
    tick();
  endtask

  task automatic test_starve();
    bit exp_q[6] = '{0, 0, 0, 0, 1, 0};
    bit seq[$];
    int last = -1;
    if_req   = 1'b1;
    mem_req  = 1'b1;
    mem_we   = 1'b0;
    mem_addr = 32'h5000;
    if_addr  = 32'h0001_0100;
    for (int c = 0; c < 40 && seq.size() < 6; c++) begin
      tick();
      if (if_done || mem_done) begin
        seq.push_back(if_done);
        if (last >= 0) begin
          checks++;
          if (c - last != LAT + 2) begin
            errors++;
            $display("FAIL starve_gap got %0d exp %0d", c - last, LAT + 2);
          end
        end
        last = c;
      end
    end
    if_req  = 1'b0;
    mem_req = 1'b0;
    checks++;
    if (seq.size() != 6) begin
      errors++;
      $display("FAIL starve_count got %0d exp 6", seq.size());
    end
    for (int i = 0; i < 6 && i < seq.size(); i++) begin
      checks++;
      if (seq[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL starve_order[%0d] got if=%0d exp if=%0d",
                 i, seq[i], exp_q[i]);
      end
    end
    tick();
    tick();
  endtask

  task automatic test_back_to_back();
    logic [AL-1:0] a[24];
    logic [DL-1:0] d[24];
    for (int c = 0; c < 24; c++) begin
      a[c]    = $urandom;
      d[c]    = $urandom;
      if_req  = 1'b1;
      if_addr = a[c];
      m_rdata = d[c];
      checks++;
      if (if_done !== (c % 4 == 3)) begin
        errors++;
        $display("FAIL b2b_done c%0d got %b exp %b", c, if_done, c % 4 == 3);
      end
      if (c % 4 == 1) begin
        checks++;
        if (m_re !== 1'b1 || m_addr !== a[c-1]) begin
          errors++;
          $display("FAIL b2b_addr c%0d got %b/%h exp 1/%h",
                   c, m_re, m_addr, a[c-1]);
        end
      end
      if (c % 4 == 3) begin
        checks++;
        if (if_rdata !== d[c-1]) begin
          errors++;
          $display("FAIL b2b_rdata c%0d got %h exp %h", c, if_rdata, d[c-1]);
        end
      end
      tick();
    end
    if_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    if_req  = 1'b1;
    if_addr = 32'h500;
    m_rdata = 32'h1234_5678;
    tick();
    if_req = 1'b0;
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({m_re, m_we, busy, if_done, mem_done} !== 5'b0) begin
      errors++;
      $display("FAIL rst_mid got %b exp 00000",
               {m_re, m_we, busy, if_done, mem_done});
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    tick();
    if_req  = 1'b1;
    if_addr = 32'h600;
    m_rdata = 32'hCAFE_F00D;
    tick();
    if_req = 1'b0;
    checks++;
    if (m_re !== 1'b1 || m_addr !== 32'h600 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_after_grant got %b/%h/%b exp 1/00000600/1",
               m_re, m_addr, busy);
    end
    tick();
    tick();
    checks++;
    if (if_done !== 1'b1 || if_rdata !== 32'hCAFE_F00D || mem_rdata !== '0) begin
      errors++;
      $display("FAIL rst_after_done got %b/%h/%h exp 1/cafef00d/0",
               if_done, if_rdata, mem_rdata);
    end
    tick();
  endtask

  task automatic test_random(input int n);
    bit            act = 0;
    int            g = 0;
    int            age = 0;
    bit            o_if = 0;
    bit            o_we = 0;
    logic [AL-1:0] o_addr = '0;
    logic [DL-1:0] o_wd = '0;
    logic [1:0]    o_len = '0;
    logic [DL-1:0] e_if = 32'hCAFE_F00D;
    logic [DL-1:0] e_mem = '0;
    for (int c = 0; c < n; c++) begin
      int  dd;
      bit  in_acc;
      bit  in_dn;
      if_req    = ($urandom_range(2) != 0);
      mem_req   = $urandom_range(1);
      mem_we    = $urandom_range(1);
      mem_len   = 2'($urandom_range(3));
      if_addr   = $urandom;
      mem_addr  = $urandom;
      mem_wdata = $urandom;
      m_rdata   = $urandom;
      @(negedge clk);
      dd     = c - g;
      in_acc = act && dd >= 1 && dd <= LAT;
      in_dn  = act && dd == LAT + 1;
      checks++;
      if ({m_re, m_we, busy} !== {in_acc && !o_we, in_acc && o_we,
                                  in_acc || in_dn}) begin
        errors++;
        $display("FAIL rnd_ctl c%0d got re/we/busy %b exp %b", c,
                 {m_re, m_we, busy},
                 {in_acc && !o_we, in_acc && o_we, in_acc || in_dn});
      end
      checks++;
      if ({if_done, mem_done} !== {in_dn && o_if, in_dn && !o_if}) begin
        errors++;
        $display("FAIL rnd_done c%0d got %b exp %b", c, {if_done, mem_done},
                 {in_dn && o_if, in_dn && !o_if});
      end
      checks++;
      if (if_rdata !== e_if || mem_rdata !== e_mem) begin
        errors++;
        $display("FAIL rnd_rdata c%0d got %h/%h exp %h/%h", c,
                 if_rdata, mem_rdata, e_if, e_mem);
      end
      if (in_acc) begin
        checks++;
        if (m_addr !== o_addr || m_len !== o_len || m_wdata !== o_wd) begin
          errors++;
          $display("FAIL rnd_port c%0d got %h/%0d/%h exp %h/%0d/%h", c,
                   m_addr, m_len, m_wdata, o_addr, o_len, o_wd);
        end
      end
      if (act && dd == LAT) begin
        if (o_if) e_if = m_rdata;
        else if (!o_we) e_mem = m_rdata;
      end
      if (act && dd == LAT + 1) begin
        act = 0;
      end else if (!act) begin
        if (mem_req && !(if_req && age == SM)) begin
          act    = 1;
          g      = c;
          o_if   = 0;
          o_we   = mem_we;
          o_addr = mem_addr;
          o_wd   = mem_wdata;
          o_len  = (mem_len == 2'd2) ? 2'd3 : mem_len;
          age    = if_req ? ((age < SM) ? age + 1 : SM) : 0;
        end else if (if_req) begin
          act    = 1;
          g      = c;
          o_if   = 1;
          o_we   = 0;
          o_addr = if_addr;
          o_wd   = '0;
          o_len  = 2'd3;
          age    = 0;
        end else begin
          age = 0;
        end
      end
      @(posedge clk);
      #1;
    end
    idle_in();
  endtask

  initial begin
    test_reset();
    test_if_alone();
    test_store();
    test_simul();
    test_starve();
    test_back_to_back();
    test_reset_mid();
    test_random(400);
    idle_in();
    repeat (LAT + 3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
